// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator.
// Each channel pulses tick once every (period+1) clocks, periodic or one-shot.
module tick_gen_multi #(
    parameter int WIDTH          = 20,
    parameter int NUM_CH         = 2,
    parameter int DEFAULT_PERIOD = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              pause,
    input  logic [NUM_CH-1:0] load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic [NUM_CH-1:0] oneshot,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [WIDTH-1:0] P_DEF = WIDTH'(DEFAULT_PERIOD);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [WIDTH-1:0] r_period;
        logic [WIDTH-1:0] r_cnt;
        logic [1:0]       r_state;
        logic             r_tick;
        logic             w_term;

        assign w_term = (r_cnt == r_period);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_period <= P_DEF;
                r_cnt    <= '0;
                r_state  <= S_IDLE;
                r_tick   <= 1'b0;
            end else if (load[g]) begin
                // A load on the terminal edge wins and restarts the count.
                r_period <= load_value;
                r_cnt    <= '0;
                r_tick   <= 1'b0;
                r_state  <= run ? S_COUNT : S_IDLE;
            end else if (!run) begin
                r_cnt   <= '0;
                r_state <= S_IDLE;
                r_tick  <= 1'b0;
            end else if (pause) begin
                r_tick <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_COUNT;
                        r_cnt   <= '0;
                        r_tick  <= 1'b0;
                    end
                    S_COUNT: begin
                        if (w_term) begin
                            r_cnt   <= '0;
                            r_tick  <= 1'b1;
                            r_state <= oneshot[g] ? S_DONE : S_COUNT;
                        end else begin
                            r_cnt  <= r_cnt + WIDTH'(1);
                            r_tick <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        r_cnt  <= '0;
                        r_tick <= 1'b0;
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_tick  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end

        assign tick[g] = r_tick;
        assign busy[g] = (r_state == S_COUNT);
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi: vector table plus hand-written corner sequences,
// expected outputs queued at drive time and checked after each edge.
module tb_tick_gen_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] load = 2'b00;
    logic [3:0] load_value = 4'd0;
    logic [1:0] oneshot = 2'b00;
    logic [1:0] tick;
    logic [1:0] busy;

    int checks = 0;
    int errors = 0;

    tick_gen_multi #(
        .WIDTH(4),
        .NUM_CH(2),
        .DEFAULT_PERIOD(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .pause(pause),
        .load(load),
        .load_value(load_value),
        .oneshot(oneshot),
        .tick(tick),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       run;
        logic       pause;
        logic [1:0] load;
        logic [3:0] lv;
        logic [1:0] os;
        logic [1:0] et;
        logic [1:0] eb;
    } vec_t;

    typedef struct {
        logic [1:0] et;
        logic [1:0] eb;
        string      nm;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[20];

    function automatic vec_t mk(
        input logic rs, input logic rn, input logic ps,
        input logic [1:0] ld, input logic [3:0] lv, input logic [1:0] os,
        input logic [1:0] et, input logic [1:0] eb);
        vec_t v;
        v.rst = rs; v.run = rn; v.pause = ps; v.load = ld;
        v.lv = lv; v.os = os; v.et = et; v.eb = eb;
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty tick=%b busy=%b", tick, busy);
        end else begin
            e = sbq.pop_front();
            if (tick !== e.et || busy !== e.eb) begin
                errors++;
                $display("FAIL %s t=%0t tick=%b busy=%b want tick=%b busy=%b",
                         e.nm, $time, tick, busy, e.et, e.eb);
            end
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        exp_t e;
        @(negedge clk);
        reset = v.rst; run = v.run; pause = v.pause;
        load = v.load; load_value = v.lv; oneshot = v.os;
        e.et = v.et; e.eb = v.eb; e.nm = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic rep(input int n, input vec_t v, input string nm);
        for (int k = 0; k < n; k++) step(v, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, then default period 3 on both channels; ch1 one-shot with P=0.
        tbl[0] = mk(1, 0, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b00);
        tbl[1] = mk(1, 0, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b00);
        for (int e = 1; e <= 13; e++)
            tbl[e+1] = mk(0, 1, 0, 2'b00, 4'd0, 2'b00,
                          (e >= 5 && (e % 4) == 1) ? 2'b11 : 2'b00, 2'b11);
        tbl[15] = mk(0, 1, 0, 2'b10, 4'd0, 2'b10, 2'b00, 2'b11);
        tbl[16] = mk(0, 1, 0, 2'b00, 4'd0, 2'b10, 2'b10, 2'b01);
        tbl[17] = mk(0, 1, 0, 2'b00, 4'd0, 2'b10, 2'b00, 2'b01);
        tbl[18] = mk(0, 1, 0, 2'b00, 4'd0, 2'b10, 2'b01, 2'b01);
        tbl[19] = mk(0, 1, 0, 2'b00, 4'd0, 2'b10, 2'b00, 2'b01);

        for (int i = 0; i < 20; i++) step(tbl[i], $sformatf("table_%0d", i));

        // Pause for 4 cycles at cnt=2 with P=5.
        step(mk(0, 1, 0, 2'b01, 4'd5, 2'b00, 2'b00, 2'b01), "p5_load");
        rep(2, mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b01), "p5_count");
        rep(4, mk(0, 1, 1, 2'b00, 4'd0, 2'b00, 2'b00, 2'b01), "pause_hold");
        rep(3, mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b01), "p5_resume");
        step(mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b01, 2'b01), "p5_tick_delayed");

        // Load on the terminal-count edge.
        rep(5, mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b01), "p5_count2");
        step(mk(0, 1, 0, 2'b01, 4'd7, 2'b00, 2'b00, 2'b01), "load_on_terminal");
        rep(7, mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b01), "p7_count");
        step(mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b01, 2'b01), "p7_tick");

        // Drop run at cnt=4 for 3 cycles; periods must survive.
        rep(4, mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b01), "p7_to_cnt4");
        rep(3, mk(0, 0, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b00), "run_low");
        step(mk(0, 1, 0, 2'b00, 4'd0, 2'b10, 2'b00, 2'b11), "rerun_start");
        step(mk(0, 1, 0, 2'b00, 4'd0, 2'b10, 2'b10, 2'b01), "rerun_ch1_shot");
        rep(6, mk(0, 1, 0, 2'b00, 4'd0, 2'b10, 2'b00, 2'b01), "rerun_count");
        step(mk(0, 1, 0, 2'b00, 4'd0, 2'b10, 2'b01, 2'b01), "rerun_p7_tick");

        // Maximum period, then reset mid-count with a load that must be ignored.
        step(mk(0, 1, 0, 2'b01, 4'd15, 2'b00, 2'b00, 2'b01), "p15_load");
        for (int r = 0; r < 2; r++) begin
            rep(15, mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b01), "p15_count");
            step(mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b01, 2'b01), "p15_tick");
        end
        rep(5, mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b01), "p15_mid");
        step(mk(1, 1, 0, 2'b11, 4'd9, 2'b00, 2'b00, 2'b00), "reset_mid");
        rep(4, mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b00, 2'b11), "post_reset");
        step(mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b11, 2'b11), "post_reset_tick");

        // Periodic P=0 ticks every unpaused cycle.
        step(mk(0, 1, 0, 2'b10, 4'd0, 2'b00, 2'b00, 2'b11), "p0_load");
        rep(2, mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b10, 2'b11), "p0_tick");
        step(mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b11, 2'b11), "p0_both");
        step(mk(0, 1, 1, 2'b00, 4'd0, 2'b00, 2'b00, 2'b11), "p0_paused");
        step(mk(0, 1, 0, 2'b00, 4'd0, 2'b00, 2'b10, 2'b11), "p0_resume");

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover count=%0d want 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
